// File: rtl/set_count.sv
// set_count: three 64-point coverage tables (A, B, C) and a scanner that counts
// the grid points satisfying a selectable set function of the three tables.
module set_count (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] set_sel,
  input  logic [5:0] table_addr,
  input  logic       table_data,
  input  logic       clr,
  input  logic       start_eval,
  input  logic [1:0] mode,
  output logic [7:0] candidate,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] ta;
  logic [63:0] tb;
  logic [63:0] tc;
  logic [1:0]  mode_q;
  logic [5:0]  addr;
  logic [6:0]  acc;
  logic        a_bit;
  logic        b_bit;
  logic        c_bit;
  logic        hit;

  // Set function of the point under the scan address, using the latched mode.
  always_comb begin
    a_bit = ta[addr];
    b_bit = tb[addr];
    c_bit = tc[addr];
    hit   = 1'b0;
    case (mode_q)
      2'b00:   hit = a_bit;
      2'b01:   hit = a_bit & b_bit;
      2'b10:   hit = a_bit ^ b_bit;
      default: hit = (a_bit & b_bit & ~c_bit) |
                     (a_bit & ~b_bit & c_bit) |
                     (~a_bit & b_bit & c_bit);
    endcase
  end

  // Table updates are only accepted while idle; a clear beats a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      ta <= '0;
      tb <= '0;
      tc <= '0;
    end else if (!busy) begin
      if (clr) begin
        ta <= '0;
        tb <= '0;
        tc <= '0;
      end else if (wr_en) begin
        case (set_sel)
          2'd0:    ta[table_addr] <= table_data;
          2'd1:    tb[table_addr] <= table_data;
          2'd2:    tc[table_addr] <= table_data;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 2'd0;
      addr      <= 6'd0;
      acc       <= 7'd0;
      candidate <= 8'd0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_eval) begin
            state  <= SCAN;
            mode_q <= mode;
            addr   <= 6'd0;
            acc    <= 7'd0;
            busy   <= 1'b1;
          end
        end
        SCAN: begin
          // 64 points at most, so the 7-bit accumulator cannot wrap.
          acc  <= acc + {6'd0, hit};
          addr <= addr + 6'd1;
          if (addr == 6'd63) state <= OUT;
        end
        OUT: begin
          candidate <= {1'b0, acc};
          valid     <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_count.sv
// Self-checking bench for set_count: a software model of the three tables
// predicts each count, which is queued at start_eval and checked at valid.
module tb_set_count;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [1:0] set_sel;
  logic [5:0] table_addr;
  logic       table_data;
  logic       clr;
  logic       start_eval;
  logic [1:0] mode;
  logic [7:0] candidate;
  logic       valid;
  logic       busy;

  int tests_run;
  int tests_failed;
  int exp_q[$];
  bit [63:0] ma, mb, mc;

  set_count dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .set_sel(set_sel),
    .table_addr(table_addr), .table_data(table_data), .clr(clr),
    .start_eval(start_eval), .mode(mode), .candidate(candidate),
    .valid(valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_count(input bit [1:0] m);
    int n = 0;
    for (int i = 0; i < 64; i++) begin
      int pop = int'(ma[i]) + int'(mb[i]) + int'(mc[i]);
      case (m)
        2'd0: n += int'(ma[i]);
        2'd1: n += int'(ma[i] & mb[i]);
        2'd2: n += int'(ma[i] ^ mb[i]);
        default: n += (pop == 2) ? 1 : 0;
      endcase
    end
    return n;
  endfunction

  task automatic write_pt(input bit [1:0] sel, input bit [5:0] a, input bit d);
    wr_en = 1'b1; set_sel = sel; table_addr = a; table_data = d;
    tick();
    wr_en = 1'b0;
    case (sel)
      2'd0: ma[a] = d;
      2'd1: mb[a] = d;
      2'd2: mc[a] = d;
      default: ;
    endcase
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ma = '0; mb = '0; mc = '0;
  endtask

  task automatic start(input bit [1:0] m);
    start_eval = 1'b1; mode = m;
    exp_q.push_back(model_count(m));
    tick();
    start_eval = 1'b0;
  endtask

  task automatic wait_valid(output int cycles, output bit seen);
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 200) begin
      if (valid === 1'b1) seen = 1'b1;
      else begin
        tick();
        cycles++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; start_eval = 1'b1;
    tick(); tick();
    rst = 1'b0; wr_en = 1'b0; start_eval = 1'b0;
    ma = '0; mb = '0; mc = '0;
    tests_run++;
    if (candidate !== 8'd0) begin
      tests_failed++; $display("[TB] FAIL reset_candidate: got %0d expected 0", candidate);
    end
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", valid);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_all_a();
    int cyc, e;
    bit seen;
    for (int i = 0; i < 64; i++) write_pt(2'd0, 6'(i), 1'b1);
    start(2'd0);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL all_a_busy: got %b expected 1", busy);
    end
    wait_valid(cyc, seen);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    tests_run++;
    if (!seen || cyc != 65) begin
      tests_failed++; $display("[TB] FAIL all_a_latency: got %0d cycles (seen=%0d) expected 65", cyc, seen);
    end
    tests_run++;
    if (candidate !== 8'd64 || candidate !== 8'(e)) begin
      tests_failed++; $display("[TB] FAIL all_a_count: got %0d expected 64 (model %0d)", candidate, e);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL all_a_busy_at_valid: got %b expected 0", busy);
    end
    tick();
    tests_run++;
    if (valid !== 1'b0 || candidate !== 8'd64) begin
      tests_failed++; $display("[TB] FAIL all_a_pulse_hold: got valid=%b cand=%0d expected valid=0 cand=64", valid, candidate);
    end
  endtask

  task automatic test_overlap();
    int cyc, e;
    bit seen;
    int want [2] = '{16, 32};
    do_clear();
    for (int i = 0; i < 32; i++) write_pt(2'd0, 6'(i), 1'b1);
    for (int i = 16; i < 48; i++) write_pt(2'd1, 6'(i), 1'b1);
    for (int k = 0; k < 2; k++) begin
      start(2'(k + 1));
      wait_valid(cyc, seen);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      tests_run++;
      if (!seen || candidate !== 8'(want[k]) || candidate !== 8'(e)) begin
        tests_failed++;
        $display("[TB] FAIL overlap_mode%0d: got %0d (seen=%0d) expected %0d", k + 1, candidate, seen, want[k]);
      end
    end
  endtask

  task automatic test_exactly_two();
    int cyc, e;
    bit seen;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      write_pt(2'd0, 6'(i), 1'b1);
      write_pt(2'd1, 6'(i + 1), 1'b1);
      write_pt(2'd2, 6'(i + 2), 1'b1);
    end
    write_pt(2'd3, 6'd10, 1'b1);
    start(2'd3);
    wait_valid(cyc, seen);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    tests_run++;
    if (!seen || candidate !== 8'd2 || candidate !== 8'(e)) begin
      tests_failed++; $display("[TB] FAIL exactly_two: got %0d (seen=%0d) expected 2", candidate, seen);
    end
    start(2'd0);
    wait_valid(cyc, seen);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    tests_run++;
    if (!seen || candidate !== 8'd3 || candidate !== 8'(e)) begin
      tests_failed++; $display("[TB] FAIL sel3_ignored: got %0d (seen=%0d) expected 3", candidate, seen);
    end
  endtask

  task automatic test_busy_ignore();
    int cyc, e, extra;
    bit seen;
    start(2'd3);
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; set_sel = 2'(i % 3); table_addr = 6'(40 + i); table_data = 1'b1;
      start_eval = 1'b1; mode = 2'd0; clr = (i == 5);
      tick();
    end
    wr_en = 1'b0; start_eval = 1'b0; clr = 1'b0;
    wait_valid(cyc, seen);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    tests_run++;
    if (!seen || candidate !== 8'd2 || candidate !== 8'(e)) begin
      tests_failed++; $display("[TB] FAIL busy_result: got %0d (seen=%0d) expected 2", candidate, seen);
    end
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (valid === 1'b1) extra++;
    end
    tests_run++;
    if (extra != 0 || candidate !== 8'd2) begin
      tests_failed++; $display("[TB] FAIL busy_single_pulse: got %0d extra pulses cand=%0d expected 0 and 2", extra, candidate);
    end
    start(2'd0);
    wait_valid(cyc, seen);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    tests_run++;
    if (!seen || candidate !== 8'd3 || candidate !== 8'(e)) begin
      tests_failed++; $display("[TB] FAIL busy_tables_kept: got %0d (seen=%0d) expected 3", candidate, seen);
    end
  endtask

  task automatic test_reset_in_scan();
    int cyc, e, pulses;
    bit seen;
    start(2'd0);
    void'(exp_q.pop_back());
    for (int i = 0; i < 30; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ma = '0; mb = '0; mc = '0;
    tests_run++;
    if (busy !== 1'b0 || valid !== 1'b0 || candidate !== 8'd0) begin
      tests_failed++; $display("[TB] FAIL scan_reset_state: got busy=%b valid=%b cand=%0d expected 0 0 0", busy, valid, candidate);
    end
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (valid === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++; $display("[TB] FAIL scan_reset_no_valid: got %0d pulses expected 0", pulses);
    end
    start(2'd0);
    wait_valid(cyc, seen);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    tests_run++;
    if (!seen || candidate !== 8'd0 || candidate !== 8'(e)) begin
      tests_failed++; $display("[TB] FAIL scan_reset_cleared: got %0d (seen=%0d) expected 0", candidate, seen);
    end
  endtask

  task automatic test_clr_vs_write();
    int cyc, e;
    bit seen;
    write_pt(2'd0, 6'd7, 1'b1);
    write_pt(2'd0, 6'd9, 1'b1);
    clr = 1'b1; wr_en = 1'b1; set_sel = 2'd0; table_addr = 6'd5; table_data = 1'b1;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    ma = '0; mb = '0; mc = '0;
    start(2'd0);
    wait_valid(cyc, seen);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    tests_run++;
    if (!seen || candidate !== 8'd0 || candidate !== 8'(e)) begin
      tests_failed++; $display("[TB] FAIL clr_beats_write: got %0d (seen=%0d) expected 0", candidate, seen);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, e;
    bit seen;
    for (int r = 0; r < 2; r++) begin
      do_clear();
      for (int t = 0; t < 3; t++)
        for (int i = 0; i < 64; i++) write_pt(2'(t), 6'(i), 1'($urandom_range(0, 1)));
      for (int m = 0; m < 4; m++) begin
        start(2'(m));
        wait_valid(cyc, seen);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        tests_run++;
        if (!seen || cyc != 65 || candidate !== 8'(e)) begin
          tests_failed++;
          $display("[TB] FAIL b2b_r%0d_m%0d: got %0d after %0d cycles expected %0d after 65", r, m, candidate, cyc, e);
        end
      end
    end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1; wr_en = 1'b0; set_sel = 2'd0; table_addr = 6'd0; table_data = 1'b0;
    clr = 1'b0; start_eval = 1'b0; mode = 2'd0;
    ma = '0; mb = '0; mc = '0;
    test_reset();
    test_all_a();
    test_overlap();
    test_exactly_two();
    test_busy_ignore();
    test_reset_in_scan();
    test_clr_vs_write();
    test_back_to_back();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/set_count.md
SET_COUNT -- requirements
Module: set_count

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-003 wr_en  input  1  write strobe for one coverage bit from the cover stage.
REQ-004 set_sel  input  2  target table for the write: 0 = A, 1 = B, 2 = C, 3 = no table written.
REQ-005 table_addr  input  6  grid point index from the cover stage, {y[2:0], x[2:0]}.
REQ-006 table_data  input  1  coverage bit: 1 = point inside the circle.
REQ-007 clr  input  1  pulse that zeroes all three tables.
REQ-008 start_eval  input  1  pulse that starts a count over the stored tables.
REQ-009 mode  input  2  set function to count; latched at start_eval.
REQ-010 candidate  output  8  count of grid points that satisfy the set function.
REQ-011 valid  output  1  one-cycle pulse; candidate holds the new result in that cycle.
REQ-012 busy  output  1  high while the block is scanning or presenting a result.

Function
REQ-013 Storage: three 64-bit tables TA, TB, TC, one bit per grid point.
REQ-014 Write rule: when wr_en=1, busy=0 and set_sel is 0, 1 or 2, the next edge writes table_data into T[set_sel][table_addr].
REQ-015 Ignored writes: set_sel=3, or wr_en=1 while busy=1, leaves all tables unchanged.
REQ-016 clr=1 while busy=0 zeroes TA, TB and TC on the next edge.
REQ-017 clr=1 while busy=1 is ignored.
REQ-018 clr=1 together with wr_en=1 in the same cycle: the clear wins and the write is dropped.
REQ-019 FSM states: IDLE, SCAN, OUT.
REQ-020 IDLE -> SCAN on start_eval=1: latch mode, set the address counter to 0, set the accumulator to 0.
REQ-021 SCAN: each cycle, evaluate f(TA[i], TB[i], TC[i]) at index i = address counter.
- Add 1 to the accumulator when f is true.
- Increment i.
REQ-022 SCAN -> OUT after i = 63 is evaluated; SCAN lasts exactly 64 cycles.
REQ-023 OUT: candidate <= final accumulator value, valid=1 for one cycle, then OUT -> IDLE.
REQ-024 Latency: start_eval sampled at edge t -> valid=1 in the cycle after edge t+65.
REQ-025 busy=1 in SCAN and OUT; busy=0 in IDLE.
REQ-026 start_eval while busy=1 is ignored; the scan in progress is not restarted.
REQ-027 Set functions, evaluated with the mode latched at start_eval:
- mode 00: A.
- mode 01: A AND B.
- mode 10: A XOR B.
- mode 11: the point is in exactly two of A, B, C.
REQ-028 Width: the accumulator is 7 bits, maximum value 64, with no wrap; candidate zero-extends it to 8 bits.
REQ-029 candidate holds its last value until the next OUT state.
REQ-030 Tables are never modified by a scan.

Reset
REQ-031 rst=1 at a clk edge forces:
- state IDLE;
- TA, TB, TC = 0;
- address counter and accumulator = 0;
- candidate = 0, valid = 0, busy = 0.
REQ-032 rst takes priority over every other input in the same cycle.
REQ-033 rst during SCAN aborts the scan with no valid pulse; the block is idle the cycle after.

Verification
REQ-034 Write all 64 points of A with 1, then start_eval with mode 00 -> valid exactly 65 cycles after the start edge, candidate=64.
REQ-035 A = points 0..31, B = points 16..47:
- mode 01 -> candidate = 16;
- mode 10 -> candidate = 32.
REQ-036 A = {0,1,2}, B = {1,2,3}, C = {2,3,4}, mode 11 -> candidate = 2 (points 1 and 3).
REQ-037 During SCAN, drive wr_en and start_eval with new values -> tables unchanged, a single valid pulse, result matches the pre-scan tables.
REQ-038 Assert rst at cycle 30 of SCAN -> no valid pulse, candidate = 0.
- Then start_eval with mode 00 on the cleared tables -> candidate = 0.
REQ-039 clr and wr_en(A, addr 5, data 1) in the same idle cycle -> mode 00 gives candidate = 0.
